// File: rtl/mod_counter.sv
// Parametrised synchronous modulo-N up/down counter with parallel load,
// wrap/saturate mode, combinational terminal count and a registered wrap pulse.
module mod_counter #(
   parameter int unsigned WIDTH    = 6,
   parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_Q  = MAX_VAL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ZERO_Q = '0;
   localparam logic [WIDTH-1:0] ONE_Q  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_next;
   logic             wrap_next;

   always_comb begin
      q_next    = q;
      wrap_next = 1'b0;
      if (load) begin
         q_next = (load_val > MAX_Q) ? MAX_Q : load_val;
      end else if (en) begin
         if (up) begin
            if (q < MAX_Q) begin
               q_next = q + ONE_Q;
            end else if (q == MAX_Q) begin
               wrap_next = 1'b1;
               q_next    = SATURATE ? q : ZERO_Q;
            end else begin
               // Out-of-range state recovers to a range end.
               wrap_next = 1'b1;
               q_next    = SATURATE ? MAX_Q : ZERO_Q;
            end
         end else begin
            if (q != ZERO_Q) begin
               q_next = q - ONE_Q;
            end else begin
               wrap_next = 1'b1;
               q_next    = SATURATE ? q : MAX_Q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q    <= '0;
         wrap <= 1'b0;
      end else begin
         q    <= q_next;
         wrap <= wrap_next;
      end
   end

   // Independent of en so it can gate a downstream counter's enable.
   assign tc = up ? (q == MAX_Q) : (q == ZERO_Q);

endmodule
